// File: rtl/dot_product_feeder_pkg.sv
// Shared definitions for the dot-product feeder: default sizes and FSM state encoding.
package dot_product_feeder_pkg;

   localparam int unsigned PIXEL_N_DEF     = 10;
   localparam int unsigned PIXEL_SIZE_DEF  = 10;
   localparam int unsigned WEIGHT_SIZE_DEF = 19;
   localparam int unsigned RESULT_W_DEF    = 26;
   localparam int unsigned CALC_CYCLES_DEF = 30;

   typedef enum logic [1:0] {
      StLoad,
      StStart,
      StWait,
      StHold
   } state_e;

endpackage

// File: rtl/dot_product_feeder_if.sv
// Element stream, engine and result signals of the dot-product feeder.
interface dot_product_feeder_if
   import dot_product_feeder_pkg::*;
#(
   parameter int unsigned PIXEL_N     = PIXEL_N_DEF,
   parameter int unsigned PIXEL_SIZE  = PIXEL_SIZE_DEF,
   parameter int unsigned WEIGHT_SIZE = WEIGHT_SIZE_DEF,
   parameter int unsigned RESULT_W    = RESULT_W_DEF
);

   logic                           in_valid;
   logic                           in_ready;
   logic [PIXEL_SIZE-1:0]          in_pixel;
   logic [WEIGHT_SIZE-1:0]         in_weight;
   logic [PIXEL_N*PIXEL_SIZE-1:0]  eng_pixels;
   logic [PIXEL_N*WEIGHT_SIZE-1:0] eng_weights;
   logic                           eng_rst;
   logic [RESULT_W-1:0]            eng_value;
   logic                           out_valid;
   logic                           out_ready;
   logic [RESULT_W-1:0]            out_value;

   // Feeder side.
   modport slave (
      input  in_valid, in_pixel, in_weight, eng_value, out_ready,
      output in_ready, eng_pixels, eng_weights, eng_rst, out_valid, out_value
   );

   // Producer / engine / consumer side.
   modport master (
      output in_valid, in_pixel, in_weight, eng_value, out_ready,
      input  in_ready, eng_pixels, eng_weights, eng_rst, out_valid, out_value
   );

endinterface

// File: rtl/dot_product_feeder.sv
// Collects PIXEL_N pixel/weight pairs, runs the external engine for CALC_CYCLES and holds
// the captured result until the consumer takes it.
module dot_product_feeder
   import dot_product_feeder_pkg::*;
#(
   parameter int unsigned PIXEL_N     = PIXEL_N_DEF,
   parameter int unsigned PIXEL_SIZE  = PIXEL_SIZE_DEF,
   parameter int unsigned WEIGHT_SIZE = WEIGHT_SIZE_DEF,
   parameter int unsigned RESULT_W    = RESULT_W_DEF,
   parameter int unsigned CALC_CYCLES = CALC_CYCLES_DEF
) (
   input logic                  clk,
   input logic                  GlobalReset,
   dot_product_feeder_if.slave  bus
);

   localparam int unsigned K_W   = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
   localparam int unsigned CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

   state_e                         state_q;
   logic [K_W-1:0]                 k_q;
   logic [CNT_W-1:0]               cnt_q;
   logic [PIXEL_N*PIXEL_SIZE-1:0]  pixels_q;
   logic [PIXEL_N*WEIGHT_SIZE-1:0] weights_q;
   logic [RESULT_W-1:0]            value_q;
   logic                           valid_q;
   logic                           ready_q;
   logic                           eng_rst_q;

   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         state_q   <= StLoad;
         k_q       <= '0;
         cnt_q     <= '0;
         pixels_q  <= '0;
         weights_q <= '0;
         value_q   <= '0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b1;
         eng_rst_q <= 1'b1;
      end else begin
         unique case (state_q)
            StLoad: begin
               if (bus.in_valid) begin
                  pixels_q[k_q*PIXEL_SIZE +: PIXEL_SIZE]   <= bus.in_pixel;
                  weights_q[k_q*WEIGHT_SIZE +: WEIGHT_SIZE] <= bus.in_weight;
                  if (k_q == K_W'(PIXEL_N - 1)) begin
                     k_q     <= '0;
                     ready_q <= 1'b0;
                     state_q <= StStart;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            StStart: begin
               // Engine has been held in restart since LOAD; release it now.
               cnt_q     <= '0;
               eng_rst_q <= 1'b0;
               state_q   <= StWait;
            end
            StWait: begin
               if (cnt_q == CNT_W'(CALC_CYCLES - 1)) begin
                  value_q   <= bus.eng_value;
                  valid_q   <= 1'b1;
                  eng_rst_q <= 1'b1;
                  state_q   <= StHold;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StHold: begin
               if (bus.out_ready) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  k_q     <= '0;
                  state_q <= StLoad;
               end
            end
            default: state_q <= StLoad;
         endcase
      end
   end

   assign bus.in_ready    = ready_q;
   assign bus.eng_pixels  = pixels_q;
   assign bus.eng_weights = weights_q;
   assign bus.eng_rst     = eng_rst_q;
   assign bus.out_valid   = valid_q;
   assign bus.out_value   = value_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Directed bench for dot_product_feeder with a serial multiply-accumulate engine model.
module tb_dot_product_feeder;

   localparam int unsigned PN = 10;
   localparam int unsigned PS = 10;
   localparam int unsigned WS = 19;
   localparam int unsigned RW = 26;
   localparam int unsigned CC = 30;

   logic clk;
   logic GlobalReset;
   int   n_checks = 0;
   int   n_fail   = 0;

   dot_product_feeder_if #(
      .PIXEL_N    (PN),
      .PIXEL_SIZE (PS),
      .WEIGHT_SIZE(WS),
      .RESULT_W   (RW)
   ) bus ();

   dot_product_feeder #(
      .PIXEL_N    (PN),
      .PIXEL_SIZE (PS),
      .WEIGHT_SIZE(WS),
      .RESULT_W   (RW),
      .CALC_CYCLES(CC)
   ) dut (
      .clk        (clk),
      .GlobalReset(GlobalReset),
      .bus        (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Engine model: one MAC per cycle while out of restart, result shown once complete.
   logic [RW-1:0] eng_acc;
   int            eng_idx;
   always @(posedge clk) begin
      if (bus.eng_rst) begin
         eng_acc <= '0;
         eng_idx <= 0;
      end else if (eng_idx < PN) begin
         eng_acc <= eng_acc + RW'(64'(bus.eng_pixels[eng_idx*PS +: PS]) *
                                  64'(bus.eng_weights[eng_idx*WS +: WS]));
         eng_idx <= eng_idx + 1;
      end
   end
   assign bus.eng_value = (eng_idx == PN) ? eng_acc : '0;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PS-1:0] pat_pix(input int pat, input int k);
      case (pat)
         0:       return PS'(k + 1);
         1:       return PS'(3 * k);
         2:       return PS'(1);
         default: return '1;
      endcase
   endfunction

   function automatic logic [WS-1:0] pat_wt(input int pat, input int k);
      case (pat)
         0:       return WS'(2);
         1:       return WS'(k + 5);
         2:       return WS'(1);
         default: return '1;
      endcase
   endfunction

   // Streams one vector; leaves the DUT in START after the last transfer edge.
   task automatic send_vector(input string name, input int pat, input int stall_at);
      int n;
      for (int k = 0; k < int'(PN); k++) begin
         if (k == stall_at) begin
            bus.in_valid  = 1'b0;
            bus.in_pixel  = '1;
            bus.in_weight = '1;
            for (int s = 0; s < 3; s++) begin
               tick();
               check({name, ":stall_ready"}, bus.in_ready, 1);
            end
         end
         bus.in_valid  = 1'b1;
         bus.in_pixel  = pat_pix(pat, k);
         bus.in_weight = pat_wt(pat, k);
         n = 0;
         while (!bus.in_ready && n < 100) begin
            tick();
            n++;
         end
         if (n >= 100) check({name, ":ready_timeout"}, n, 0);
         tick();
      end
      // Keep junk on the input to show it is ignored outside LOAD.
      bus.in_pixel  = '1;
      bus.in_weight = '1;
   endtask

   task automatic run_job(input string name, input int pat, input int stall_at,
                          input int hold_cycles, input bit early_ready,
                          input logic [RW-1:0] exp_val);
      logic [PN*PS-1:0] ep;
      logic [PN*WS-1:0] ew;
      int               n;
      int               rst_seen;
      for (int k = 0; k < int'(PN); k++) begin
         ep[k*PS +: PS] = pat_pix(pat, k);
         ew[k*WS +: WS] = pat_wt(pat, k);
      end
      send_vector(name, pat, stall_at);
      check({name, ":start_ready"}, bus.in_ready, 0);
      check({name, ":start_rst"}, bus.eng_rst, 1);
      if (early_ready) bus.out_ready = 1'b1;
      tick();
      check({name, ":wait_rst"}, bus.eng_rst, 0);
      n        = 0;
      rst_seen = 0;
      while (!bus.out_valid && n < int'(CC) + 20) begin
         if (bus.eng_rst) rst_seen++;
         tick();
         n++;
      end
      check({name, ":latency"}, n, CC);
      check({name, ":rst_in_wait"}, rst_seen, 0);
      check({name, ":value"}, bus.out_value, exp_val);
      check({name, ":pixels"}, bus.eng_pixels, ep);
      check({name, ":weights"}, bus.eng_weights, ew);
      check({name, ":hold_rst"}, bus.eng_rst, 1);
      bus.in_valid = 1'b0;
      if (!early_ready) begin
         for (int h = 0; h < hold_cycles; h++) begin
            tick();
            check({name, ":hold_valid"}, bus.out_valid, 1);
            check({name, ":hold_value"}, bus.out_value, exp_val);
            check({name, ":hold_ready"}, bus.in_ready, 0);
         end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check({name, ":after_valid"}, bus.out_valid, 0);
      check({name, ":after_ready"}, bus.in_ready, 1);
   endtask

   initial begin
      GlobalReset   = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pixel  = '0;
      bus.in_weight = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst:in_ready", bus.in_ready, 1);
      check("rst:out_valid", bus.out_valid, 0);
      check("rst:eng_rst", bus.eng_rst, 1);
      check("rst:out_value", bus.out_value, 0);
      check("rst:pixels", bus.eng_pixels, 0);
      check("rst:weights", bus.eng_weights, 0);
      GlobalReset = 1'b0;
      tick();

      run_job("basic", 0, -1, 0, 1'b1, 26'd110);
      run_job("stall", 1, 4, 5, 1'b0, 26'd1530);

      // Abort a job in WAIT once the counter has reached 12.
      send_vector("abort", 0, -1);
      bus.in_valid = 1'b0;
      tick();
      repeat (12) tick();
      GlobalReset = 1'b1;
      #1;
      check("abort:out_valid", bus.out_valid, 0);
      check("abort:pixels", bus.eng_pixels, 0);
      check("abort:weights", bus.eng_weights, 0);
      check("abort:eng_rst", bus.eng_rst, 1);
      tick();
      GlobalReset = 1'b0;
      tick();
      check("abort:in_ready", bus.in_ready, 1);
      check("abort:out_valid2", bus.out_valid, 0);
      run_job("after_abort", 0, -1, 2, 1'b0, 26'd110);

      run_job("b2b_ones", 2, -1, 0, 1'b0, 26'd10);
      run_job("b2b_max", 3, -1, 0, 1'b0, 26'd61855754);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dot_product_feeder.md
DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

Interface
REQ-001 SHALL have parameter PIXEL_N, default 10, number of elements per vector.
REQ-002 SHALL have parameter PIXEL_SIZE, default 10, pixel element width in bits.
REQ-003 SHALL have parameter WEIGHT_SIZE, default 19, weight element width in bits.
REQ-004 SHALL have parameter RESULT_W, default 26, dot-product result width in bits.
REQ-005 SHALL have parameter CALC_CYCLES, default 30, engine cycles from start release to result valid.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port GlobalReset, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1, upstream element valid.
REQ-009 SHALL have port in_ready, output, 1, feeder accepts an element this cycle.
REQ-010 SHALL have port in_pixel, input, PIXEL_SIZE, pixel element.
REQ-011 SHALL have port in_weight, input, WEIGHT_SIZE, weight element.
REQ-012 SHALL have port eng_pixels, output, PIXEL_N*PIXEL_SIZE, packed pixel vector to engine.
REQ-013 SHALL have port eng_weights, output, PIXEL_N*WEIGHT_SIZE, packed weight vector to engine.
REQ-014 SHALL have port eng_rst, output, 1, synchronous restart to engine.
REQ-015 SHALL have port eng_value, input, RESULT_W, engine result.
REQ-016 SHALL have port out_valid, output, 1, result valid.
REQ-017 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-018 SHALL have port out_value, output, RESULT_W, captured dot product.

Function
REQ-019 SHALL implement states LOAD, START, WAIT, HOLD.
REQ-020 SHALL assert in_ready only in LOAD; transfer = in_valid & in_ready.
REQ-021 SHALL, on transfer k (k = 0..PIXEL_N-1), write in_pixel to eng_pixels[k*PIXEL_SIZE +: PIXEL_SIZE] and in_weight to eng_weights[k*WEIGHT_SIZE +: WEIGHT_SIZE]; then increment k.
REQ-022 SHALL, on transfer with k = PIXEL_N-1, reset k to 0 and go to START next cycle.
REQ-023 SHALL hold eng_pixels and eng_weights stable outside LOAD.
REQ-024 SHALL assert eng_rst for exactly one cycle in START, then go to WAIT with cycle counter cleared.
REQ-025 SHALL, in WAIT, count CALC_CYCLES cycles; on the last, register eng_value into out_value and go to HOLD.
REQ-026 SHALL assert eng_rst continuously in LOAD and HOLD, so the engine stays idle between jobs.
REQ-027 SHALL assert out_valid only in HOLD; out_value stable while out_valid is high.
REQ-028 SHALL, on out_valid & out_ready, go to LOAD next cycle with k = 0; first new element accepted one cycle after the handshake.
REQ-029 SHALL ignore in_valid outside LOAD and ignore out_ready outside HOLD.
REQ-030 SHALL treat in_valid low mid-vector as a stall: k and state are held.
REQ-031 SHALL carry result width unchanged; no truncation, saturation or sign handling.

Reset
REQ-032 SHALL, on GlobalReset high, immediately set state LOAD, k 0, counter 0, eng_pixels 0, eng_weights 0, out_value 0, out_valid 0, eng_rst 1.
REQ-033 SHALL, on GlobalReset mid-job in any state, discard the partial vector or result; in_ready becomes 1 in the first cycle after release.

Structure
REQ-034 SHALL place the state encoding and default parameter values in the shared project package.
REQ-035 SHALL be a single module; the dot-product engine is instantiated by the parent, not inside this block.

Verification
REQ-036 Ten elements pixel=k+1 and weight=2 with in_valid always high -> in_ready low after 10th; one eng_rst pulse; out_valid after CALC_CYCLES; out_value = model value 110 from the engine.
REQ-037 in_valid dropped for 3 cycles after element 4 -> k holds at 4; packed vectors identical to the no-stall case.
REQ-038 out_ready low for 5 cycles in HOLD -> out_valid and out_value stable; in_ready 0 throughout; LOAD one cycle after the handshake.
REQ-039 GlobalReset asserted in WAIT at counter 12 -> out_valid 0, vectors 0, in_ready 1 after release; the next full job produces the correct result.
REQ-040 Two jobs back-to-back (all-ones, then pixel 1023 / weight 2^19-1) -> two results in order, none lost or duplicated; second vector fully overwrites the first.
